// File: rtl/maquina_estados.sv
// maquina_estados: control FSM for the transaction-layer FIFO/counter datapath.
// Drives the state bus consumed by the counter bank and read mux, keeps a
// sticky per-FIFO error record and owns the almost-full/almost-empty
// thresholds, which can only be loaded while in INIT.
module maquina_estados #(
    parameter int unsigned NUM_FIFOS = 5,
    parameter int unsigned UMBRAL_W  = 3,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DEF_ALTO  = 6,
    parameter int unsigned DEF_BAJO  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    input  logic [NUM_FIFOS-1:0] fifo_error,
    input  logic [UMBRAL_W-1:0]  umbral_alto_in,
    input  logic [UMBRAL_W-1:0]  umbral_bajo_in,
    output logic [3:0]           state,
    output logic                 idle,
    output logic [NUM_FIFOS-1:0] error_out,
    output logic [UMBRAL_W-1:0]  umbral_alto,
    output logic [UMBRAL_W-1:0]  umbral_bajo
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'h0,
        ST_INIT   = 4'h1,
        ST_IDLE   = 4'h2,
        ST_ACTIVE = 4'h3,
        ST_ERROR  = 4'h4
    } state_t;

    localparam int unsigned MAX_ALTO = DEPTH - 1;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_idle;
    logic [NUM_FIFOS-1:0]  r_error;
    logic [UMBRAL_W-1:0]   r_alto;
    logic [UMBRAL_W-1:0]   r_bajo;

    logic                  w_any_error;
    logic                  w_all_empty;
    logic                  w_pair_ok;
    logic                  w_latch;

    assign w_any_error = |fifo_error;
    assign w_all_empty = &fifo_empty;
    // A candidate pair is legal only if low < high and high fits the FIFO depth.
    assign w_pair_ok   = (umbral_bajo_in < umbral_alto_in) &&
                         (32'(umbral_alto_in) <= MAX_ALTO);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and threshold-latch enable; errors pre-empt init.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        case (r_state)
            ST_RESET: begin
                w_next_state = ST_INIT;
            end
            ST_INIT: begin
                if (w_any_error) begin
                    w_next_state = ST_ERROR;
                end else begin
                    w_latch = w_pair_ok;
                    if (init) begin
                        w_next_state = ST_INIT;
                    end else if (w_all_empty) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_ACTIVE;
                    end
                end
            end
            ST_IDLE: begin
                if (w_any_error) begin
                    w_next_state = ST_ERROR;
                end else if (init) begin
                    w_next_state = ST_INIT;
                end else if (!w_all_empty) begin
                    w_next_state = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_any_error) begin
                    w_next_state = ST_ERROR;
                end else if (init) begin
                    w_next_state = ST_INIT;
                end else if (w_all_empty) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ERROR: begin
                w_next_state = ST_ERROR;
            end
            default: begin
                w_next_state = ST_RESET;
            end
        endcase
    end

    // idle is registered from the next state so it changes on the same edge as state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle <= 1'b0;
        end else begin
            r_idle <= (w_next_state == ST_IDLE);
        end
    end

    // Sticky error record; accumulates in every state except RESET.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= '0;
        end else if (r_state != ST_RESET) begin
            r_error <= r_error | fifo_error;
        end
    end

    // Thresholds only change on a legal, error-free cycle spent in INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alto <= UMBRAL_W'(DEF_ALTO);
            r_bajo <= UMBRAL_W'(DEF_BAJO);
        end else if (w_latch) begin
            r_alto <= umbral_alto_in;
            r_bajo <= umbral_bajo_in;
        end
    end

    assign state       = r_state;
    assign idle        = r_idle;
    assign error_out   = r_error;
    assign umbral_alto = r_alto;
    assign umbral_bajo = r_bajo;

endmodule
